// File: rtl/control_miscare_param.sv
// control_miscare_param: clocked motion controller for the line-follower car.
// Synchronises an N-sensor line array and runs an INACTIV/URMARIRE/CAUTARE/FINAL FSM.
// The FSM drives direction codes and duty-compare values for both motor drivers.
// A debounced lap counter stops the car according to the selected circuit mode.
// Optional feature macro: RAMPA_PWM_EN. When defined, rising duty values slew by +1 per clock.
// Latency from a senzori change to the outputs is 3 clocks:
//   2 clocks of synchroniser plus 1 registered output stage.
module control_miscare_param #(
  parameter int              NR_SENZORI   = 5,
  parameter int              DC_W         = 12,
  parameter logic [DC_W-1:0] DC_MAX       = 12'h999,
  parameter logic [DC_W-1:0] DC_CORECTIE  = 12'h400,
  parameter int              DEBOUNCE_CIC = 16,
  parameter int              TIMEOUT_CIC  = 50000,
  parameter int              TURE_CURBE   = 10,
  parameter int              TURE_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NR_SENZORI-1:0] senzori,
  input  logic [1:0]            circuit,
  output logic [1:0]            directie_driverA,
  output logic [1:0]            directie_driverB,
  output logic [DC_W-1:0]       factor_dc_driverA,
  output logic [DC_W-1:0]       factor_dc_driverB,
  output logic                  semnal_dreapta,
  output logic                  semnal_stanga,
  output logic                  stop,
  output logic                  tact_count,
  output logic [TURE_W-1:0]     count_ture,
  output logic [2:0]            stare
);

  localparam int C     = (NR_SENZORI - 1) / 2;
  localparam int DEB_W = $clog2(DEBOUNCE_CIC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CIC + 1);

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b00;
  localparam logic [1:0] DIR_REV   = 2'b01;

  // Encoding of the remembered deviation side.
  localparam logic [1:0] PARTE_NIMIC   = 2'b00;
  localparam logic [1:0] PARTE_DREAPTA = 2'b01;
  localparam logic [1:0] PARTE_STANGA  = 2'b10;

  typedef enum logic [2:0] {
    INACTIV  = 3'd0,
    URMARIRE = 3'd1,
    CAUTARE  = 3'd2,
    FINAL    = 3'd3
  } stare_t;

  stare_t                  st, nxt;
  logic [NR_SENZORI-1:0]   s1, s2;
  logic                    dev_dr, dev_st, centru, fin;
  logic                    oprire;
  logic [1:0]              parte, parte_nxt;
  logic [TMO_W-1:0]        tmo;
  logic [DEB_W-1:0]        deb;
  logic [1:0]              tgt_dir_a, tgt_dir_b;
  logic [DC_W-1:0]         tgt_dc_a, tgt_dc_b;
  logic                    tgt_stop;

  assign stare = st;

  // Two-flop synchroniser for the asynchronous sensor array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= senzori;
      s2 <= s1;
    end
  end

  // Sensor decode on the synchronised array.
  // Index 0 is the outermost right sensor; the highest index is the outermost left sensor.
  always_comb begin
    dev_dr = |s2[C-1:1];
    dev_st = |s2[NR_SENZORI-2:C+1];
    centru = s2[C];
    fin    = s2[0] & s2[NR_SENZORI-1] & dev_dr & dev_st;
  end

  // Next state and output targets. Outputs are computed from the state being entered,
  // so the registered outputs always match the registered state.
  always_comb begin
    nxt       = st;
    parte_nxt = parte;
    tgt_dir_a = DIR_BRAKE;
    tgt_dir_b = DIR_BRAKE;
    tgt_dc_a  = '0;
    tgt_dc_b  = '0;
    tgt_stop  = 1'b1;
    // Stop rule uses the already-updated lap count, so it acts the cycle after a lap.
    oprire = ((circuit == 2'b01) && (count_ture != '0)) ||
             ((circuit == 2'b10) && (count_ture >= TURE_W'(TURE_CURBE)));

    case (st)
      INACTIV:  if (circuit != 2'b00) nxt = URMARIRE;
      URMARIRE: begin
        if (oprire)                             nxt = FINAL;
        else if (!centru && !dev_dr && !dev_st) nxt = CAUTARE;
      end
      CAUTARE: begin
        if (oprire)                                  nxt = FINAL;
        else if (centru || dev_dr || dev_st)         nxt = URMARIRE;
        else if (tmo == TMO_W'(TIMEOUT_CIC - 1))     nxt = FINAL;
      end
      FINAL:    nxt = FINAL;
      default:  nxt = INACTIV;
    endcase
    if (circuit == 2'b00) nxt = INACTIV;

    case (nxt)
      URMARIRE: begin
        tgt_stop  = 1'b0;
        tgt_dir_a = DIR_FWD;
        tgt_dir_b = DIR_FWD;
        tgt_dc_a  = DC_MAX;
        tgt_dc_b  = DC_MAX;
        // A single-sided deviation slows the wheel on that side.
        // Both sides set (finish line or all-high) means drive straight.
        if (dev_dr && !dev_st) begin
          tgt_dc_a  = DC_CORECTIE;
          parte_nxt = PARTE_DREAPTA;
        end else if (dev_st && !dev_dr) begin
          tgt_dc_b  = DC_CORECTIE;
          parte_nxt = PARTE_STANGA;
        end
      end
      CAUTARE: begin
        tgt_stop = 1'b1;
        tgt_dc_a = DC_MAX;
        tgt_dc_b = DC_MAX;
        if (parte == PARTE_DREAPTA) begin
          tgt_dir_a = DIR_REV;
          tgt_dir_b = DIR_FWD;
        end else if (parte == PARTE_STANGA) begin
          tgt_dir_a = DIR_FWD;
          tgt_dir_b = DIR_REV;
        end else begin
          tgt_dir_a = DIR_FWD;
          tgt_dir_b = DIR_FWD;
          tgt_dc_a  = DC_CORECTIE;
          tgt_dc_b  = DC_CORECTIE;
        end
      end
      INACTIV:  parte_nxt = PARTE_NIMIC;
      default:  parte_nxt = parte;
    endcase
  end

  // FSM state, search timeout and all registered motion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st                <= INACTIV;
      parte             <= PARTE_NIMIC;
      tmo               <= '0;
      directie_driverA  <= DIR_BRAKE;
      directie_driverB  <= DIR_BRAKE;
      factor_dc_driverA <= '0;
      factor_dc_driverB <= '0;
      stop              <= 1'b1;
      semnal_dreapta    <= 1'b0;
      semnal_stanga     <= 1'b0;
    end else begin
      st               <= nxt;
      parte            <= parte_nxt;
      tmo              <= (st == CAUTARE && nxt == CAUTARE) ? tmo + TMO_W'(1) : '0;
      directie_driverA <= tgt_dir_a;
      directie_driverB <= tgt_dir_b;
      stop             <= tgt_stop;
      semnal_dreapta   <= s2[0];
      semnal_stanga    <= s2[NR_SENZORI-1];
`ifdef RAMPA_PWM_EN
      factor_dc_driverA <= (tgt_dc_a > factor_dc_driverA) ? factor_dc_driverA + DC_W'(1) : tgt_dc_a;
      factor_dc_driverB <= (tgt_dc_b > factor_dc_driverB) ? factor_dc_driverB + DC_W'(1) : tgt_dc_b;
`else
      factor_dc_driverA <= tgt_dc_a;
      factor_dc_driverB <= tgt_dc_b;
`endif
    end
  end

  // Lap counter: a lap counts once the finish pattern has lasted DEBOUNCE_CIC cycles.
  // The debounce counter then holds until the pattern drops, giving one lap per crossing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb        <= '0;
      count_ture <= '0;
      tact_count <= 1'b0;
    end else if (circuit == 2'b00) begin
      deb        <= '0;
      count_ture <= '0;
      tact_count <= 1'b0;
    end else begin
      tact_count <= 1'b0;
      if (!fin) begin
        deb <= '0;
      end else if (deb != DEB_W'(DEBOUNCE_CIC)) begin
        deb <= deb + DEB_W'(1);
        if (deb == DEB_W'(DEBOUNCE_CIC - 1)) begin
          tact_count <= 1'b1;
          if (count_ture != '1) count_ture <= count_ture + TURE_W'(1);
        end
      end
    end
  end

endmodule
